// File: rtl/proc_engine.sv
// Iterative accumulation engine: arithmetic-progression sum and sum of squares
// of the low 32 bits of each term, driven by level-change commands from the host.
module proc_engine (
  input  logic        clk,
  input  logic        nRESET,
  input  logic [3:0]  proc_cmd,
  input  logic [31:0] niter,
  input  logic [63:0] constK,
  input  logic [63:0] const1,
  input  logic [63:0] const2,
  output logic [3:0]  proc_status,
  output logic [63:0] proc_acc_dout,
  output logic [63:0] proc_pow_acc_dout,
  output logic [31:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_START = 4'h1;
  localparam logic [3:0] CMD_STOP  = 4'h2;
  localparam logic [3:0] CMD_CLEAR = 4'h3;

  state_t      r_state;
  logic [3:0]  r_cmd_prev;
  logic [31:0] r_niter;
  logic [63:0] r_const1;
  logic [63:0] r_const2;
  logic [63:0] r_t;
  logic [63:0] r_acc;
  logic [63:0] r_pow;
  logic [63:0] r_sq;
  logic        r_sq_valid;
  logic [31:0] r_iter;
  logic        r_ovf;
  logic        r_err;
  logic        r_busy;
  logic        r_done;

  logic        w_evt;
  logic        w_active;
  logic [64:0] w_acc_sum;
  logic [64:0] w_pow_sum;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_pow_nxt;
  logic [63:0] w_sq;
  logic [31:0] w_iter_nxt;
  logic        w_run_end;

  assign w_evt      = (proc_cmd != r_cmd_prev);
  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  // Carry-out of the 65-bit sums selects the saturated value.
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_t};
  assign w_pow_sum  = {1'b0, r_pow} + {1'b0, r_sq};
  assign w_acc_nxt  = w_acc_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : w_acc_sum[63:0];
  assign w_pow_nxt  = w_pow_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : w_pow_sum[63:0];
  assign w_sq       = 64'(r_t[31:0]) * 64'(r_t[31:0]);
  assign w_iter_nxt = r_iter + 32'd1;
  assign w_run_end  = (w_iter_nxt == r_niter) ||
                      ((r_const2 != 64'd0) && (w_acc_nxt >= r_const2));

  // Command decode, FSM and datapath registers.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= S_IDLE;
      r_cmd_prev <= 4'h0;
      r_niter    <= 32'd0;
      r_const1   <= 64'd0;
      r_const2   <= 64'd0;
      r_t        <= 64'd0;
      r_acc      <= 64'd0;
      r_pow      <= 64'd0;
      r_sq       <= 64'd0;
      r_sq_valid <= 1'b0;
      r_iter     <= 32'd0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cmd_prev <= proc_cmd;
      if (w_evt && (proc_cmd == CMD_CLEAR)) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_acc      <= 64'd0;
        r_pow      <= 64'd0;
        r_iter     <= 32'd0;
        r_ovf      <= 1'b0;
        r_err      <= 1'b0;
        r_sq_valid <= 1'b0;
      end else if (w_evt && (proc_cmd == CMD_STOP) && w_active) begin
        // Pending square is dropped; acc, pow and iter_cnt freeze.
        r_state    <= S_HALT;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_sq_valid <= 1'b0;
      end else if (w_evt && (proc_cmd == CMD_START) && !w_active) begin
        r_niter    <= niter;
        r_const1   <= const1;
        r_const2   <= const2;
        r_t        <= constK;
        r_acc      <= 64'd0;
        r_pow      <= 64'd0;
        r_sq       <= 64'd0;
        r_sq_valid <= 1'b0;
        r_iter     <= 32'd0;
        r_ovf      <= 1'b0;
        if (niter == 32'd0) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      end else begin
        if (w_evt && ((proc_cmd == CMD_START) || (proc_cmd >= 4'h4))) begin
          r_err <= 1'b1;
        end
        case (r_state)
          S_RUN: begin
            r_acc      <= w_acc_nxt;
            r_sq       <= w_sq;
            r_sq_valid <= 1'b1;
            r_t        <= r_t + r_const1;
            r_iter     <= w_iter_nxt;
            if (r_sq_valid) begin
              r_pow <= w_pow_nxt;
            end
            if (w_acc_sum[64] || (r_sq_valid && w_pow_sum[64])) begin
              r_ovf <= 1'b1;
            end
            if (w_run_end) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            r_pow <= w_pow_nxt;
            if (w_pow_sum[64]) begin
              r_ovf <= 1'b1;
            end
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign proc_status       = {r_err, r_ovf, r_done, r_busy};
  assign proc_acc_dout     = r_acc;
  assign proc_pow_acc_dout = r_pow;
  assign iter_cnt          = r_iter;

endmodule

// File: tb/tb_proc_engine.sv
// Directed and randomized bench for proc_engine, checked against a
// term-by-term arithmetic reference model.
module tb_proc_engine;

  logic        clk;
  logic        nRESET;
  logic [3:0]  proc_cmd;
  logic [31:0] niter;
  logic [63:0] constK;
  logic [63:0] const1;
  logic [63:0] const2;
  logic [3:0]  proc_status;
  logic [63:0] proc_acc_dout;
  logic [63:0] proc_pow_acc_dout;
  logic [31:0] iter_cnt;

  int  n_cmp;
  int  n_bad;
  bit  exp_err;

  proc_engine dut (
    .clk               (clk),
    .nRESET            (nRESET),
    .proc_cmd          (proc_cmd),
    .niter             (niter),
    .constK            (constK),
    .const1            (const1),
    .const2            (const2),
    .proc_status       (proc_status),
    .proc_acc_dout     (proc_acc_dout),
    .proc_pow_acc_dout (proc_pow_acc_dout),
    .iter_cnt          (iter_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Saturating 64-bit add; flags overflow on carry-out.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          inout bit ovf);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[64]) begin
      ovf = 1'b1;
      return 64'hFFFF_FFFF_FFFF_FFFF;
    end
    return s[63:0];
  endfunction

  // Reference: walk the progression term by term, summing terms and squares.
  task automatic model(input logic [63:0] k0, input logic [63:0] inc, input logic [63:0] thr,
                       input logic [31:0] n, output logic [63:0] acc, output logic [63:0] pow,
                       output int k, output bit ovf);
    logic [63:0] t;
    logic [63:0] sq;
    t = k0; acc = 64'd0; pow = 64'd0; k = 0; ovf = 1'b0;
    while (n != 32'd0) begin
      sq  = 64'(t[31:0]) * 64'(t[31:0]);
      acc = sat_add(acc, t, ovf);
      pow = sat_add(pow, sq, ovf);
      k++;
      t = t + inc;
      if ((k == int'(n)) || ((thr != 64'd0) && (acc >= thr))) break;
    end
  endtask

  task automatic send(input logic [3:0] code);
    @(posedge clk);
    #1 proc_cmd = code;
  endtask

  // Launch a run and check busy at the last iteration edge and results after drain.
  task automatic do_run(input string tag, input logic [63:0] k0, input logic [63:0] inc,
                        input logic [63:0] thr, input logic [31:0] n, input bit scramble);
    logic [63:0] e_acc;
    logic [63:0] e_pow;
    int          e_k;
    bit          e_ovf;
    model(k0, inc, thr, n, e_acc, e_pow, e_k, e_ovf);
    constK = k0; const1 = inc; const2 = thr; niter = n;
    send(4'h0);
    send(4'h1);
    @(posedge clk);
    #1;
    if (scramble) begin
      constK = {$urandom, $urandom}; const1 = {$urandom, $urandom};
      const2 = {$urandom, $urandom}; niter = $urandom;
    end
    if (e_k > 0) begin
      repeat (e_k) @(posedge clk);
      #1 chk({tag, "_busy"}, 64'(proc_status[1:0]), 64'd1);
      @(posedge clk);
      #1;
    end
    chk({tag, "_status"}, 64'(proc_status), 64'({exp_err, e_ovf, 1'b1, 1'b0}));
    chk({tag, "_acc"}, proc_acc_dout, e_acc);
    chk({tag, "_pow"}, proc_pow_acc_dout, e_pow);
    chk({tag, "_iter"}, 64'(iter_cnt), 64'(e_k));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_status"}, 64'(proc_status), 64'd0);
    chk({tag, "_acc"}, proc_acc_dout, 64'd0);
    chk({tag, "_pow"}, proc_pow_acc_dout, 64'd0);
    chk({tag, "_iter"}, 64'(iter_cnt), 64'd0);
  endtask

  initial begin
    logic [63:0] rk, rc1, rc2;
    logic [31:0] rn;
    n_cmp = 0; n_bad = 0; exp_err = 1'b0;
    nRESET = 1'b0; proc_cmd = 4'h0; niter = 32'd0;
    constK = 64'd0; const1 = 64'd0; const2 = 64'd0;
    #35;
    chk_zero("reset");
    nRESET = 1'b1;

    do_run("tp1", 64'd1, 64'd1, 64'd0, 32'd4, 1'b0);
    chk("tp1_acc_lit", proc_acc_dout, 64'd10);
    chk("tp1_pow_lit", proc_pow_acc_dout, 64'd30);

    do_run("tp2", 64'd1, 64'd1, 64'd5, 32'd4, 1'b0);
    chk("tp2_acc_lit", proc_acc_dout, 64'd6);
    chk("tp2_pow_lit", proc_pow_acc_dout, 64'd14);

    do_run("sat", 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 32'd2, 1'b0);
    chk("sat_acc_lit", proc_acc_dout, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_pow_lit", proc_pow_acc_dout, 64'hFFFF_FFFF_FFFF_FFFF);

    do_run("n0", 64'd9, 64'd3, 64'd0, 32'd0, 1'b0);

    // STOP after ten iterations, then CLEAR.
    constK = 64'd1; const1 = 64'd1; const2 = 64'd0; niter = 32'd1000;
    send(4'h0);
    send(4'h1);
    repeat (11) @(posedge clk);
    #1 proc_cmd = 4'h2;
    @(posedge clk);
    #1;
    chk("halt_status", 64'(proc_status), 64'd0);
    chk("halt_acc", proc_acc_dout, 64'd55);
    chk("halt_pow", proc_pow_acc_dout, 64'd285);
    chk("halt_iter", 64'(iter_cnt), 64'd10);
    repeat (5) @(posedge clk);
    #1;
    chk("halt_acc_hold", proc_acc_dout, 64'd55);
    chk("halt_iter_hold", 64'(iter_cnt), 64'd10);
    send(4'h3);
    @(posedge clk);
    #1 chk_zero("clear");

    // Illegal code mid-run: run completes with err set.
    constK = 64'd5; const1 = 64'd7; const2 = 64'd0; niter = 32'd100;
    send(4'h0);
    send(4'h1);
    repeat (20) @(posedge clk);
    #1 proc_cmd = 4'h7;
    exp_err = 1'b1;
    repeat (81) @(posedge clk);
    #1 chk("ill_busy", 64'(proc_status), 64'b1001);
    @(posedge clk);
    #1;
    chk("ill_status", 64'(proc_status), 64'b1010);
    chk("ill_acc", proc_acc_dout, 64'd35150);
    chk("ill_iter", 64'(iter_cnt), 64'd100);
    send(4'h3);
    exp_err = 1'b0;
    @(posedge clk);
    #1 chk_zero("clear2");

    for (int i = 0; i < 8; i++) begin
      rn = 32'($urandom_range(1, 20));
      if (i % 3 == 2) begin
        rk = {$urandom, $urandom}; rc1 = {$urandom, $urandom}; rc2 = {$urandom, $urandom};
      end else begin
        rk = 64'($urandom_range(0, 1000)); rc1 = 64'($urandom_range(0, 300));
        rc2 = (i % 2 == 0) ? 64'd0 : 64'($urandom_range(1, 8000));
      end
      do_run($sformatf("rnd%0d", i), rk, rc1, rc2, rn, 1'b1);
    end

    // Asynchronous reset in the middle of a run.
    constK = 64'd3; const1 = 64'd2; const2 = 64'd0; niter = 32'd50;
    send(4'h0);
    send(4'h1);
    repeat (10) @(posedge clk);
    #5 nRESET = 1'b0;
    #1 chk_zero("areset");
    proc_cmd = 4'h0;
    #8 nRESET = 1'b1;
    @(posedge clk);
    #1 chk_zero("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
